ls299_load_seq: RTL and testbench

- Upstream sequencer for the ls299 8-bit universal shift register.
- Accepts parallel bytes over a valid/ready handshake and drives the ls299 S, G_b, D, SL, SR and CLR_b pins, so each byte is serialised gaplessly on QH (LSB first) or QA (MSB first).
- Emits a strobe aligned to the cycle in which each serial bit is valid at the ls299 output.
- Sits between a byte source (FIFO or CPU register) and the ls299 instance.

---
 rtl/ls299_pkg.sv | 25 ++
 rtl/ls299_load_seq.sv | 142 ++++++++++++++
 tb/tb_ls299_load_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ls299_pkg.sv
// ls299_pkg: shared definitions for the ls299 upstream load sequencer.
//   S_*          : ls299 mode-pin encodings {S1,S0}
//   PARITY_ODD   : constant folded into the optional word parity
//   seq_state_t  : sequencer state
//   shift_code() : mode code that moves bits toward the chosen serial pin
package ls299_pkg;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  localparam logic PARITY_ODD = 1'b0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_t;

  // Right shift drains QH (LSB first); left shift drains QA (MSB first).
  function automatic logic [1:0] shift_code(input bit msb_first);
    return msb_first ? S_SHL : S_SHR;
  endfunction

endpackage

// File: rtl/ls299_load_seq.sv
// ls299_load_seq: accepts bytes over valid/ready and drives an ls299 so that
// each byte is serialised gaplessly on QH (LSB first) or QA (MSB first),
// with a strobe aligned to every valid serial bit.
//
// Parameters: NBITS (1..8 bits strobed per word), MSB_FIRST, FILL.
// Ports:
//   CK, RST          clock (rising edge), synchronous active-high reset
//   in_data/in_valid/in_ready   byte handshake (in_ready combinational)
//   pause            downstream stall, freezes serialisation
//   S, G_b, D, SR, SL, CLR_b    ls299 control pins (S, D registered)
//   bit_strobe/bit_first/bit_last  serial-bit qualifiers (registered)
//   busy             sequencer not idle
// Optional: define LS299_LOAD_SEQ_PARITY_EN to add a registered 'parity'
// output holding the parity of the low NBITS of the last accepted word.
module ls299_load_seq
  import ls299_pkg::*;
#(
  parameter int unsigned NBITS     = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter logic        FILL      = 1'b0
) (
  input  logic       CK,
  input  logic       RST,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       pause,
  output logic [1:0] S,
  output logic [1:0] G_b,
  output logic [7:0] D,
  output logic       SR,
  output logic       SL,
  output logic       CLR_b,
  output logic       bit_strobe,
  output logic       bit_first,
  output logic       bit_last,
  output logic       busy
`ifdef LS299_LOAD_SEQ_PARITY_EN
  ,
  output logic       parity
`endif
);

  localparam logic [1:0] SHC      = shift_code(MSB_FIRST);
  localparam logic [2:0] CNT_INIT = 3'(NBITS - 1);

  seq_state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] s_q, s_d;
  logic [7:0] d_q, d_d;
  logic       strobe_q, strobe_d;
  logic       first_q, first_d;
  logic       last_q, last_d;
  logic       accept;

  // A new word may be taken while idle or while the final shift of the
  // current word is being issued; that is what makes the stream gapless.
  assign in_ready = ~RST & ~pause &
                    ((state_q == IDLE) | ((state_q == SHIFT) & (cnt_q == '0)));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = S_HOLD;
    d_d     = d_q;
    if (accept) begin
      s_d     = S_LOAD;
      d_d     = in_data;
      cnt_d   = CNT_INIT;
      state_d = SHIFT;
    end else if (!pause && state_q == SHIFT) begin
      if (cnt_q != '0) begin
        s_d   = SHC;
        cnt_d = cnt_q - 3'd1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // The command sitting in s_q executes at the coming edge, so its bit is
  // visible one cycle later: the strobe flags are derived from s_q. In the
  // cycle a word's final command is presented, cnt_q has already reached 0.
  always_comb begin
    strobe_d = (s_q == S_LOAD) | (s_q == SHC);
    first_d  = (s_q == S_LOAD);
    last_d   = strobe_d & (state_q == SHIFT) & (cnt_q == '0);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      s_q      <= S_HOLD;
      d_q      <= '0;
      strobe_q <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      d_q      <= d_d;
      strobe_q <= strobe_d;
      first_q  <= first_d;
      last_q   <= last_d;
    end
  end

`ifdef LS299_LOAD_SEQ_PARITY_EN
  localparam logic [7:0] MASK = 8'((1 << NBITS) - 1);

  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (accept) parity_d = (^(in_data & MASK)) ^ PARITY_ODD;
  end

  always_ff @(posedge CK) begin
    if (RST) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end

  assign parity = parity_q;
`else
  // Parity output not built.
`endif

  assign S          = s_q;
  assign D          = d_q;
  assign G_b        = 2'b00;
  assign SR         = FILL;
  assign SL         = FILL;
  assign CLR_b      = ~RST;
  assign bit_strobe = strobe_q;
  assign bit_first  = first_q;
  assign bit_last   = last_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ls299_load_seq.sv
// Bench for ls299_load_seq: three sequencer instances (8b LSB-first,
// 4b MSB-first with FILL=1, 1b LSB-first) each driving a behavioural ls299.
// A scoreboard of expected serial bits (pushed per accepted word) is
// checked against the ls299 serial pin on every strobe.
module tb_ls299_load_seq;
  import ls299_pkg::*;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       pause = 1'b0;
  logic [7:0] din [3];
  logic       vin [3];
  logic       rdy [3];
  logic       stb [3];
  logic       fst [3];
  logic       lst [3];
  logic       bsy [3];
  logic       srp [3];
  logic       slp [3];
  logic       clrb[3];
  logic [1:0] s   [3];
  logic [1:0] gb  [3];
  logic [7:0] dd  [3];
  logic [7:0] q   [3];
`ifdef LS299_LOAD_SEQ_PARITY_EN
  logic       par [3];
`endif

  int total = 0;
  int bad   = 0;

  logic [2:0]  exq [3][64];
  int          wp [3];
  int          rp [3];
  int          nstb [3];
  int          run [3];
  int          maxrun [3];
  logic [15:0] lg [3];

  initial forever #5 CK = ~CK;

  ls299_load_seq #(.NBITS(8), .MSB_FIRST(1'b0), .FILL(1'b0)) dut0 (
    .CK(CK), .RST(RST), .in_data(din[0]), .in_valid(vin[0]), .in_ready(rdy[0]),
    .pause(pause), .S(s[0]), .G_b(gb[0]), .D(dd[0]), .SR(srp[0]), .SL(slp[0]),
    .CLR_b(clrb[0]), .bit_strobe(stb[0]), .bit_first(fst[0]), .bit_last(lst[0]),
    .busy(bsy[0])
`ifdef LS299_LOAD_SEQ_PARITY_EN
    , .parity(par[0])
`endif
  );

  ls299_load_seq #(.NBITS(4), .MSB_FIRST(1'b1), .FILL(1'b1)) dut1 (
    .CK(CK), .RST(RST), .in_data(din[1]), .in_valid(vin[1]), .in_ready(rdy[1]),
    .pause(pause), .S(s[1]), .G_b(gb[1]), .D(dd[1]), .SR(srp[1]), .SL(slp[1]),
    .CLR_b(clrb[1]), .bit_strobe(stb[1]), .bit_first(fst[1]), .bit_last(lst[1]),
    .busy(bsy[1])
`ifdef LS299_LOAD_SEQ_PARITY_EN
    , .parity(par[1])
`endif
  );

  ls299_load_seq #(.NBITS(1), .MSB_FIRST(1'b0), .FILL(1'b0)) dut2 (
    .CK(CK), .RST(RST), .in_data(din[2]), .in_valid(vin[2]), .in_ready(rdy[2]),
    .pause(pause), .S(s[2]), .G_b(gb[2]), .D(dd[2]), .SR(srp[2]), .SL(slp[2]),
    .CLR_b(clrb[2]), .bit_strobe(stb[2]), .bit_first(fst[2]), .bit_last(lst[2]),
    .busy(bsy[2])
`ifdef LS299_LOAD_SEQ_PARITY_EN
    , .parity(par[2])
`endif
  );

  // Behavioural ls299: q[i] holds D[i]; QA = q[7], QH = q[0].
  always @(posedge CK) begin
    for (int k = 0; k < 3; k++) begin
      if (!clrb[k]) q[k] <= 8'h00;
      else begin
        case (s[k])
          2'b01:   q[k] <= {srp[k], q[k][7:1]};
          2'b10:   q[k] <= {q[k][6:0], slp[k]};
          2'b11:   q[k] <= dd[k];
          default: q[k] <= q[k];
        endcase
      end
    end
  end

  function automatic int nbits_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 4 : 1;
  endfunction

  function automatic bit msb_of(input int k);
    return (k == 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic compare_loop();
    logic       ser;
    logic       bv;
    logic [2:0] e;
    logic [7:0] w;
    int         nb;
    forever begin
      @(negedge CK);
      for (int k = 0; k < 3; k++) begin
        ser = msb_of(k) ? q[k][7] : q[k][0];
        total++;
        if (stb[k]) begin
          if (rp[k] == wp[k]) begin
            bad++;
            $display("FAIL stream%0d: strobe=1 with no bit pending, expected strobe=0", k);
          end else begin
            e = exq[k][rp[k] % 64];
            rp[k]++;
            if ({ser, fst[k], lst[k]} !== e) begin
              bad++;
              $display("FAIL stream%0d: {bit,first,last} got %b expected %b", k,
                       {ser, fst[k], lst[k]}, e);
            end
          end
          nstb[k]++;
          run[k]++;
          lg[k] = {lg[k][14:0], ser};
          if (run[k] > maxrun[k]) maxrun[k] = run[k];
        end else begin
          run[k] = 0;
          if (fst[k] || lst[k]) begin
            bad++;
            $display("FAIL flags%0d: first=%0d last=%0d without strobe, expected 0", k,
                     fst[k], lst[k]);
          end
        end
        if (RST) rp[k] = wp[k];
        else if (vin[k] && rdy[k]) begin
          w  = din[k];
          nb = nbits_of(k);
          for (int j = 0; j < nb; j++) begin
            bv = msb_of(k) ? w[7 - j] : w[j];
            exq[k][wp[k] % 64] = {bv, (j == 0), (j == nb - 1)};
            wp[k]++;
          end
        end
      end
    end
  endtask

  task automatic send(input int k, input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    din[k] = w;
    vin[k] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (rdy[k]) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    chk("handshake", int'(ok), 1);
  endtask

  initial begin
    int base;
    for (int k = 0; k < 3; k++) begin
      din[k] = 8'h00; vin[k] = 1'b0;
      wp[k] = 0; rp[k] = 0; nstb[k] = 0; run[k] = 0; maxrun[k] = 0; lg[k] = '0;
    end
    fork
      compare_loop();
    join_none

    // Reset
    tick(); tick();
    chk("rst_S", int'(s[0]), 0);
    chk("rst_strobe", int'(stb[0]), 0);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_ready", int'(rdy[0]), 0);
    chk("rst_clrb", int'(clrb[0]), 0);
    chk("rst_gb", int'(gb[0]), 0);
    chk("rst_q", int'(q[0]), 0);
    RST = 1'b0;
    #1;
    chk("rel_ready", int'(rdy[0]), 1);
    chk("rel_clrb", int'(clrb[0]), 1);
    chk("fill1_sl", int'(slp[1]), 1);
    chk("fill1_sr", int'(srp[1]), 1);
    chk("fill0_sr", int'(srp[0]), 0);
    tick();

    // Single word A5, LSB first on QH: 1,0,1,0,0,1,0,1
    base = nstb[0]; maxrun[0] = 0;
    send(0, 8'hA5); vin[0] = 1'b0;
    repeat (14) tick();
    chk("a5_count", nstb[0] - base, 8);
    chk("a5_bits", int'(lg[0][7:0]), 8'b1010_0101);
    chk("a5_run", maxrun[0], 8);
    chk("a5_idle", int'(bsy[0]), 0);
    chk("a5_drained", wp[0] - rp[0], 0);
`ifdef LS299_LOAD_SEQ_PARITY_EN
    chk("a5_parity", int'(par[0]), 0);
`endif

    // Back-to-back 0F, F0: 16 contiguous strobes 1111 0000 0000 1111
    base = nstb[0]; maxrun[0] = 0;
    send(0, 8'h0F); send(0, 8'hF0); vin[0] = 1'b0;
    repeat (20) tick();
    chk("b2b_count", nstb[0] - base, 16);
    chk("b2b_bits", int'(lg[0]), 16'hF00F);
    chk("b2b_run", maxrun[0], 16);
    chk("b2b_drained", wp[0] - rp[0], 0);

    // MSB first, NBITS=4: C3 -> QA 1,1,0,0
    base = nstb[1]; maxrun[1] = 0;
    send(1, 8'hC3); vin[1] = 1'b0;
    repeat (10) tick();
    chk("c3_count", nstb[1] - base, 4);
    chk("c3_bits", int'(lg[1][3:0]), 4'b1100);
    chk("c3_run", maxrun[1], 4);
    chk("c3_idle", int'(bsy[1]), 0);

    // NBITS=1 back-to-back: bit0 of 01,00,01,01 -> 1,0,1,1, no bubble
    base = nstb[2]; maxrun[2] = 0;
    send(2, 8'h01); send(2, 8'h00); send(2, 8'h01); send(2, 8'h01); vin[2] = 1'b0;
    repeat (6) tick();
    chk("n1_count", nstb[2] - base, 4);
    chk("n1_bits", int'(lg[2][3:0]), 4'b1011);
    chk("n1_run", maxrun[2], 4);
    chk("n1_idle", int'(bsy[2]), 0);

    // Pause for 3 cycles after the 3rd strobe of 81
    base = nstb[0]; maxrun[0] = 0;
    send(0, 8'h81); vin[0] = 1'b0;
    for (int i = 0; i < 30 && (nstb[0] - base) < 3; i++) tick();
    chk("pause_reach", nstb[0] - base, 3);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_S", int'(s[0]), 0);
      chk("pause_ready", int'(rdy[0]), 0);
      if (i > 0) chk("pause_strobe", int'(stb[0]), 0);
    end
    pause = 1'b0;
    repeat (16) tick();
    chk("pause_count", nstb[0] - base, 8);
    chk("pause_bits", int'(lg[0][7:0]), 8'b1000_0001);
    chk("pause_gap", int'(maxrun[0] < 8), 1);
    chk("pause_idle", int'(bsy[0]), 0);

    // Reset after the 4th bit of FF
    base = nstb[0];
    send(0, 8'hFF); vin[0] = 1'b0;
    for (int i = 0; i < 30 && (nstb[0] - base) < 4; i++) tick();
    chk("mid_reach", int'((nstb[0] - base) >= 4), 1);
    RST = 1'b1;
    tick();
    chk("mid_strobe", int'(stb[0]), 0);
    chk("mid_q", int'(q[0]), 0);
    chk("mid_S", int'(s[0]), 0);
    chk("mid_ready", int'(rdy[0]), 0);
    chk("mid_busy", int'(bsy[0]), 0);
    RST = 1'b0;
    #1;
    chk("mid_rel_ready", int'(rdy[0]), 1);
    tick();
    base = nstb[0];
    repeat (10) tick();
    chk("mid_no_stray", nstb[0] - base, 0);

`ifdef LS299_LOAD_SEQ_PARITY_EN
    send(0, 8'h07); vin[0] = 1'b0;
    repeat (12) tick();
    chk("parity_07", int'(par[0]), 1);
    chk("parity_07_bits", int'(lg[0][7:0]), 8'b1110_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
